multicycle_control: RTL and testbench

Multicycle control FSM for the 32-bit datapath. It sequences each instruction through fetch, decode, execute, memory and write-back. It drives the Select inputs of the datapath's 32-bit 2:1 muxes (ALU B-source, write-back source, PC source) and the register/memory enables. Memory accesses use a request/ready handshake. A retired-instruction counter supports bring-up and performance checks.

---
 rtl/multicycle_control_pkg.sv | 43 ++++
 rtl/multicycle_control_retire_counter.sv | 30 +++
 rtl/multicycle_control.sv | 131 +++++++++++++
 tb/tb_multicycle_control.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared constants and types for the multicycle control FSM: opcodes,
// state encodings, ALU operation codes and the control-word bundle.
package multicycle_control_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;

   typedef enum logic [3:0] {
      ST_FETCH  = 4'd0,
      ST_DECODE = 4'd1,
      ST_EXEC_R = 4'd2,
      ST_WB_R   = 4'd3,
      ST_EXEC_I = 4'd4,
      ST_WB_I   = 4'd5,
      ST_ADDR   = 4'd6,
      ST_MEM_RD = 4'd7,
      ST_WB_MEM = 4'd8,
      ST_MEM_WR = 4'd9,
      ST_BRANCH = 4'd10
   } state_e;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'b00,
      ALU_SUB   = 2'b01,
      ALU_FUNCT = 2'b10
   } alu_op_e;

   typedef struct packed {
      logic    pc_write;
      logic    ir_write;
      logic    reg_write;
      logic    mem_read;
      logic    mem_write;
      logic    alu_src_sel;
      logic    mem_to_reg_sel;
      logic    pc_src_sel;
      alu_op_e alu_op;
   } ctrl_t;

endpackage

// File: rtl/multicycle_control_retire_counter.sv
// Retired-instruction counter: synchronous active-low clear, increment
// enable, free-running wrap from all-ones back to zero.
module multicycle_control_retire_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (!clr_n) begin
         count_d = '0;
      end else if (inc) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/write-back,
// drives datapath mux selects and enables, and counts retired instructions.
module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             Clk,
   input  logic             ResetN,
   input  logic [5:0]       Opcode,
   input  logic             Zero,
   input  logic             MemReady,
   output logic             PCWrite,
   output logic             IRWrite,
   output logic             RegWrite,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             ALUSrcSel,
   output logic             MemToRegSel,
   output logic             PCSrcSel,
   output logic [1:0]       ALUOp,
   output logic             Illegal,
   output logic [3:0]       State,
   output logic [CNT_W-1:0] RetiredCnt
);

   state_e state_q, state_d;
   logic   illegal_q, illegal_d;
   ctrl_t  ctrl;
   logic   retire;

   always_ff @(posedge Clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      // NOTE: reset is synchronous; ResetN is only looked at on the clock edge.
      if (!ResetN) begin
         state_q   <= ST_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      // NOTE: defaults first so no path through the case can infer a latch.
      state_d   = ST_FETCH;
      illegal_d = illegal_q;
      case (state_q)
         ST_FETCH:  state_d = MemReady ? ST_DECODE : ST_FETCH;
         ST_DECODE: begin
            case (Opcode)
               OP_RTYPE:     state_d = ST_EXEC_R;
               OP_ADDI:      state_d = ST_EXEC_I;
               OP_LW, OP_SW: state_d = ST_ADDR;
               OP_BEQ:       state_d = ST_BRANCH;
               default:      illegal_d = 1'b1;
            endcase
         end
         ST_EXEC_R: state_d = ST_WB_R;
         ST_EXEC_I: state_d = ST_WB_I;
         ST_ADDR:   state_d = (Opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
         ST_MEM_RD: state_d = MemReady ? ST_WB_MEM : ST_MEM_RD;
         ST_MEM_WR: state_d = MemReady ? ST_FETCH : ST_MEM_WR;
         default:   state_d = ST_FETCH;
      endcase
   end

   // Everything below is forced idle while ResetN is low, so an aborted
   // instruction can neither assert an enable nor retire.
   always_comb begin
      ctrl   = '0;
      retire = 1'b0;
      if (ResetN) begin
         case (state_q)
            ST_FETCH: begin
               ctrl.mem_read = 1'b1;
               ctrl.ir_write = MemReady;
               ctrl.pc_write = MemReady;
            end
            ST_EXEC_R: ctrl.alu_op = ALU_FUNCT;
            ST_EXEC_I, ST_ADDR: begin
               ctrl.alu_src_sel = 1'b1;
               ctrl.alu_op      = ALU_ADD;
            end
            ST_WB_R, ST_WB_I: begin
               ctrl.reg_write = 1'b1;
               retire         = 1'b1;
            end
            ST_MEM_RD: ctrl.mem_read = 1'b1;
            ST_WB_MEM: begin
               ctrl.reg_write      = 1'b1;
               ctrl.mem_to_reg_sel = 1'b1;
               retire              = 1'b1;
            end
            ST_MEM_WR: begin
               ctrl.mem_write = 1'b1;
               retire         = MemReady;
            end
            ST_BRANCH: begin
               ctrl.alu_op     = ALU_SUB;
               ctrl.pc_src_sel = 1'b1;
               ctrl.pc_write   = Zero;
               retire          = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign PCWrite     = ctrl.pc_write;
   assign IRWrite     = ctrl.ir_write;
   assign RegWrite    = ctrl.reg_write;
   assign MemRead     = ctrl.mem_read;
   assign MemWrite    = ctrl.mem_write;
   assign ALUSrcSel   = ctrl.alu_src_sel;
   assign MemToRegSel = ctrl.mem_to_reg_sel;
   assign PCSrcSel    = ctrl.pc_src_sel;
   assign ALUOp       = ctrl.alu_op;
   assign Illegal     = ResetN ? illegal_q : 1'b0;
   assign State       = ResetN ? state_q : ST_FETCH;

   multicycle_control_retire_counter #(
      .CNT_W(CNT_W)
   ) u_retire_counter (
      .clk  (Clk),
      .clr_n(ResetN),
      .inc  (retire),
      .count(RetiredCnt)
   );

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: an instruction-level model checks
// every cycle, and hand-computed literals pin the key sequences.
module tb_multicycle_control;
   import multicycle_control_pkg::*;

   logic        Clk = 1'b0;
   logic        ResetN = 1'b0;
   logic [5:0]  Opcode = 6'h00;
   logic        Zero = 1'b0;
   logic        MemReady = 1'b0;
   logic        PCWrite, IRWrite, RegWrite, MemRead, MemWrite;
   logic        ALUSrcSel, MemToRegSel, PCSrcSel, Illegal;
   logic [1:0]  ALUOp;
   logic [3:0]  State;
   logic [31:0] RetiredCnt;

   int n_checks = 0;
   int n_errors = 0;

   // Instruction-level model, advanced on each rising edge.
   int          m_state = 0;
   logic [31:0] m_cnt = '0;
   logic        m_ill = 1'b0;
   int          preload_seq = 0;
   int          seen_seq = 0;
   logic [31:0] preload_val = '0;

   always #5 Clk = ~Clk;

   multicycle_control #(.CNT_W(32)) dut (
      .Clk(Clk), .ResetN(ResetN), .Opcode(Opcode), .Zero(Zero),
      .MemReady(MemReady), .PCWrite(PCWrite), .IRWrite(IRWrite),
      .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
      .ALUSrcSel(ALUSrcSel), .MemToRegSel(MemToRegSel), .PCSrcSel(PCSrcSel),
      .ALUOp(ALUOp), .Illegal(Illegal), .State(State), .RetiredCnt(RetiredCnt)
   );

   always @(posedge Clk) begin : model
      bit done;
      done = 1'b0;
      if (preload_seq != seen_seq) begin
         seen_seq = preload_seq;
         m_cnt    = preload_val;
      end
      if (!ResetN) begin
         m_state = 0;
         m_cnt   = '0;
         m_ill   = 1'b0;
      end else begin
         case (m_state)
            0: if (MemReady) m_state = 1;
            1: begin
               if (Opcode == OP_RTYPE) m_state = 2;
               else if (Opcode == OP_ADDI) m_state = 4;
               else if (Opcode == OP_LW || Opcode == OP_SW) m_state = 6;
               else if (Opcode == OP_BEQ) m_state = 10;
               else begin m_ill = 1'b1; m_state = 0; end
            end
            2: m_state = 3;
            4: m_state = 5;
            6: m_state = (Opcode == OP_LW) ? 7 : 9;
            7: if (MemReady) m_state = 8;
            9: done = MemReady;
            3, 5, 8, 10: done = 1'b1;
            default: m_state = 0;
         endcase
         if (done) begin
            m_cnt   = m_cnt + 32'd1;
            m_state = 0;
         end
      end
   end

   // Control word {PCW,IRW,RegW,MemRd,MemWr,ALUSrc,MemToReg,PCSrc,ALUOp}.
   function automatic logic [9:0] exp_ctrl(input int st, input logic rdy, input logic z);
      case (st)
         0:       return {rdy, rdy, 8'b0100_0000};
         2:       return 10'b00_0000_0010;
         3, 5:    return 10'b00_1000_0000;
         4, 6:    return 10'b00_0001_0000;
         7:       return 10'b00_0100_0000;
         8:       return 10'b00_1000_1000;
         9:       return 10'b00_0010_0000;
         10:      return {z, 9'b0_0000_0101};
         default: return 10'b00_0000_0000;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [9:0] act_ctrl();
      return {PCWrite, IRWrite, RegWrite, MemRead, MemWrite,
              ALUSrcSel, MemToRegSel, PCSrcSel, ALUOp};
   endfunction

   task automatic compare_model();
      check("ctrl", 32'(act_ctrl()), 32'(ResetN ? exp_ctrl(m_state, MemReady, Zero) : 10'd0));
      check("state", 32'(State), ResetN ? 32'(m_state) : 32'd0);
      check("illegal", 32'(Illegal), 32'(ResetN & m_ill));
      check("rd_wr_excl", 32'(MemRead & MemWrite), 32'd0);
      if (ResetN) check("retired", RetiredCnt, m_cnt);
   endtask

   // Apply one cycle of inputs at the falling edge, then check the model.
   task automatic drive(input logic rst, input logic [5:0] op, input logic rdy, input logic z);
      @(negedge Clk);
      ResetN   = rst;
      Opcode   = op;
      MemReady = rdy;
      Zero     = z;
      #2;
      compare_model();
   endtask

   int rd_cycles;

   initial begin
      drive(1'b0, OP_RTYPE, 1'b1, 1'b0);
      drive(1'b0, OP_RTYPE, 1'b1, 1'b0);
      check("rst_state", 32'(State), 32'd0);
      check("rst_memread", 32'(MemRead), 32'd0);

      // RTYPE, zero-wait: states 0,1,2,3
      drive(1'b1, OP_RTYPE, 1'b1, 1'b0);
      check("r_fetch_ir", 32'(IRWrite), 32'd1);
      drive(1'b1, OP_RTYPE, 1'b1, 1'b0);
      check("r_decode", 32'(State), 32'd1);
      drive(1'b1, OP_RTYPE, 1'b1, 1'b0);
      check("r_exec_aluop", 32'(ALUOp), 32'd2);
      drive(1'b1, OP_RTYPE, 1'b1, 1'b0);
      check("r_wb_regwrite", 32'({RegWrite, MemToRegSel}), 32'b10);

      // LW with three wait cycles in MEM_RD
      drive(1'b1, OP_LW, 1'b1, 1'b0);
      check("r_retired", RetiredCnt, 32'd1);
      drive(1'b1, OP_LW, 1'b1, 1'b0);
      drive(1'b1, OP_LW, 1'b1, 1'b0);
      check("lw_addr", 32'({State, ALUSrcSel}), {27'd0, 4'd6, 1'b1});
      rd_cycles = 0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, OP_LW, (i == 3), 1'b0);
         if (State == 4'd7 && MemRead) rd_cycles++;
      end
      check("lw_memrd_cycles", 32'(rd_cycles), 32'd4);
      drive(1'b1, OP_LW, 1'b1, 1'b0);
      check("lw_wb", 32'({State, RegWrite, MemToRegSel}), {26'd0, 4'd8, 2'b11});

      // BEQ taken then not taken
      for (int b = 0; b < 2; b++) begin
         drive(1'b1, OP_BEQ, 1'b1, 1'b0);
         drive(1'b1, OP_BEQ, 1'b1, 1'b0);
         drive(1'b1, OP_BEQ, 1'b1, (b == 0));
         check("beq_pcwrite", 32'({PCWrite, PCSrcSel}), (b == 0) ? 32'b11 : 32'b01);
      end

      // Illegal opcode, then ADDI
      drive(1'b1, 6'h3F, 1'b1, 1'b0);
      check("beq_retired", RetiredCnt, 32'd4);
      drive(1'b1, 6'h3F, 1'b1, 1'b0);
      check("ill_decode", 32'(Illegal), 32'd0);
      drive(1'b1, OP_ADDI, 1'b1, 1'b0);
      check("ill_after", 32'({Illegal, State}), 32'b1_0000);
      check("ill_no_retire", RetiredCnt, 32'd4);
      drive(1'b1, OP_ADDI, 1'b1, 1'b0);
      drive(1'b1, OP_ADDI, 1'b1, 1'b0);
      check("addi_exec", 32'({State, ALUSrcSel, ALUOp}), {25'd0, 4'd4, 1'b1, 2'b00});
      drive(1'b1, OP_ADDI, 1'b1, 1'b0);
      check("addi_wb", 32'(RegWrite), 32'd1);

      // SW aborted by reset during the MEM_WR wait
      drive(1'b1, OP_SW, 1'b1, 1'b0);
      check("addi_retired", RetiredCnt, 32'd5);
      check("ill_sticky", 32'(Illegal), 32'd1);
      drive(1'b1, OP_SW, 1'b1, 1'b0);
      drive(1'b1, OP_SW, 1'b1, 1'b0);
      drive(1'b1, OP_SW, 1'b0, 1'b0);
      check("sw_wait", 32'({State, MemWrite}), {27'd0, 4'd9, 1'b1});
      drive(1'b0, OP_SW, 1'b1, 1'b0);
      check("rst_abort_outs", 32'({act_ctrl(), State, Illegal}), 32'd0);
      drive(1'b1, OP_SW, 1'b0, 1'b0);
      check("rst_abort_state", 32'({State, Illegal}), 32'd0);
      check("rst_abort_cnt", RetiredCnt, 32'd0);

      // Counter wrap via preload
      drive(1'b1, OP_SW, 1'b1, 1'b0);
      preload_val = 32'hFFFF_FFFF;
      force dut.u_retire_counter.count_q = 32'hFFFF_FFFF;
      #1;
      release dut.u_retire_counter.count_q;
      preload_seq++;
      drive(1'b1, OP_SW, 1'b1, 1'b0);
      check("preload", RetiredCnt, 32'hFFFF_FFFF);
      drive(1'b1, OP_SW, 1'b1, 1'b0);
      drive(1'b1, OP_SW, 1'b1, 1'b0);
      check("sw_memwr", 32'(MemWrite), 32'd1);
      drive(1'b1, OP_SW, 1'b1, 1'b0);
      check("wrap_zero", RetiredCnt, 32'd0);
      drive(1'b1, OP_SW, 1'b1, 1'b0);
      drive(1'b1, OP_SW, 1'b1, 1'b0);
      drive(1'b1, OP_SW, 1'b1, 1'b0);
      drive(1'b1, OP_RTYPE, 1'b0, 1'b0);
      check("wrap_one", RetiredCnt, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
